// File: rtl/mem_test_responder_if.sv
// Request/response bus between the march-test controller (master) and the
// memory-test responder (slave).
interface mem_test_responder_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          wren;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          busy;

  modport master (
    output req, wren, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, wren, addr, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/mem_test_responder.sv
// Single-port synchronous RAM acting as the responder of the memory-test bus.
// One request at a time: accept in IDLE, wait WAIT cycles, access in RESP,
// then a registered one-cycle ack carrying the read data.
// Optional macro MEM_FAULT_INJECT_EN adds a stuck-at fault on the read path
// (ports fault_en, fault_addr, fault_bit, fault_val).
module mem_test_responder #(
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int WAIT = 1
) (
  input logic                 clk,
  input logic                 rst,
  mem_test_responder_if.slave bus
`ifdef MEM_FAULT_INJECT_EN
  ,
  input logic                 fault_en,
  input logic [AW-1:0]        fault_addr,
  input logic [$clog2(DW)-1:0] fault_bit,
  input logic                 fault_val
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          resp;
  logic [3:0]    cnt;
  logic          wren_l;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] wdata_l;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rd_word;
  logic          ack_q;
  logic          busy_q;

  logic [DW-1:0] mem [2**AW];

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode plus the accept/respond strobes that steer the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    resp      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          accept    = 1'b1;
          state_nxt = (WAIT > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP: begin
        resp      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read word as seen by the requester, optionally with one stuck-at bit.
  always_comb begin
    rd_word = mem[addr_l];
`ifdef MEM_FAULT_INJECT_EN
    if (fault_en && (addr_l == fault_addr)) rd_word[fault_bit] = fault_val;
`endif
  end

  // Request latches, wait counter and the registered ack/busy/rdata outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 4'd0;
      wren_l  <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= resp;
      if (accept) begin
        wren_l  <= bus.wren;
        addr_l  <= bus.addr;
        wdata_l <= bus.wdata;
        cnt     <= 4'(WAIT);
        busy_q  <= 1'b1;
      end else begin
        if (state == S_WAIT) cnt <= cnt - 4'd1;
        // busy spans the ack cycle and drops on the edge that ends it
        if (ack_q) busy_q <= 1'b0;
      end
      if (resp && !wren_l) rdata_q <= rd_word;
    end
  end

  // Storage array: never reset, written only on the RESP edge of a write.
  always_ff @(posedge clk) begin
    if (resp && wren_l) mem[addr_l] <= wdata_l;
  end

endmodule
